fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum cycles spent in WAIT_LOW plus WAIT_HIGH before a transaction is aborted; legal range 8..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  bit i: requester i has an operation pending; held until acked or withdrawn.
REQ-005 req_op  input  2  bit i: requester i operation, 0 add, 1 subtract.
REQ-006 req_a  input  64  [32i+31:32i]: requester i left operand, IEEE-754 single.
REQ-007 req_b  input  64  [32i+31:32i]: requester i right operand.
REQ-008 req_ack  output  2  bit i: one-cycle grant/capture strobe for requester i.
REQ-009 rsp_valid  output  2  bit i: one-cycle result strobe for requester i.
REQ-010 rsp_data  output  32  result of the most recent transaction.
REQ-011 rsp_timeout  output  1  qualifies rsp_valid; 1 means the transaction was aborted.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 fpu_start, fpu_op  output  1 each  drive the FPU start and op inputs.
REQ-014 fpu_a, fpu_b  output  32 each  drive the FPU A and B inputs.
REQ-015 fpu_ready  input  1  FPU ready output.
REQ-016 fpu_c  input  32  FPU result output.
REQ-017 fpu_rst  output  1  FPU reset; equals rst OR an internal one-cycle abort pulse.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ABORT, RESP.
REQ-019 IDLE: if any req_valid set, grant one requester, assert its req_ack combinationally, capture its op/a/b into fpu_op/fpu_a/fpu_b on that edge, and go to ISSUE; else stay.
REQ-020 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; a lone valid requester is always granted; after reset requester 0 has priority.
REQ-021 A requester deasserting req_valid before req_ack SHALL be treated as withdrawn with no side effects.
REQ-022 ISSUE: fpu_start = fpu_ready, combinational; go to WAIT_LOW on the edge where fpu_ready=1; otherwise stay, with fpu_start low.
REQ-023 fpu_op/fpu_a/fpu_b SHALL stay constant from capture until the state returns to IDLE, covering the FPU's operand sampling one cycle after start.
REQ-024 WAIT_LOW: go to WAIT_HIGH when fpu_ready=0. WAIT_HIGH: when fpu_ready=1, register fpu_c into rsp_data, clear rsp_timeout, and go to RESP.
REQ-025 The timeout counter SHALL clear on entry to WAIT_LOW and increment each cycle in WAIT_LOW/WAIT_HIGH; on reaching TIMEOUT, go to ABORT.
REQ-026 ABORT, exactly one cycle: fpu_rst high, rsp_data <= 32'h7FC00000, rsp_timeout <= 1, then go to RESP.
REQ-027 RESP, exactly one cycle: rsp_valid bit of the granted requester high, then go to IDLE; no new grant occurs in RESP.
REQ-028 rsp_data and rsp_timeout SHALL hold their values until the next RESP.
REQ-029 Normal latency SHALL be: req_ack cycle, then ISSUE at +1, then rsp_valid one cycle after fpu_ready returns high.
REQ-030 A timeout firing in the same cycle fpu_ready rises in WAIT_HIGH SHALL take the normal completion path; completion wins.

Reset
REQ-031 While rst is high: state IDLE, last grant = 1, counter 0, req_ack=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0, fpu_start=0, fpu_op=0, fpu_a=fpu_b=0, fpu_rst=1.
REQ-032 rst asserted mid-transaction SHALL abandon the transaction immediately with no rsp_valid; the aborted requester must re-request.

Verification
REQ-033 req_valid=01, A=3F800000, B=40000000, op=0 -> req_ack=01 for 1 cycle, fpu_start 1 cycle, later rsp_valid=01, rsp_data=40400000, rsp_timeout=0.
REQ-034 req_valid=11 held for two transactions after reset -> grant order 0,1, then 0 again on a third request; each rsp_valid bit matches its grant.
REQ-035 Real FPU, A=B=3F800000, op=1 (FPU normalisation never terminates) -> after TIMEOUT cycles fpu_rst pulses 1 cycle, rsp_data=7FC00000, rsp_timeout=1, then IDLE.
REQ-036 FPU stub holding fpu_ready=0 for 5 cycles while in ISSUE -> fpu_start stays low, then pulses exactly once when fpu_ready=1.
REQ-037 rst asserted during WAIT_HIGH -> all outputs at reset values the same cycle, no rsp_valid; a new request after release completes normally.
REQ-038 req_valid[1] dropped the cycle before its grant while req_valid[0]=1 -> requester 0 granted; requester 1 gets no ack or rsp.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a single-precision add/sub FPU.
// Sequences start/ready handshakes and aborts a hung FPU after TIMEOUT cycles.
module fpu_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [1:0]  req_ack,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        fpu_start,
  output logic        fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_ready,
  input  logic [31:0] fpu_c,
  output logic        fpu_rst
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ABORT, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        fpu_op_q, fpu_op_d;
  logic [31:0] fpu_a_q, fpu_a_d;
  logic [31:0] fpu_b_q, fpu_b_d;
  logic        grant_sel;
  logic        timeout_hit;
  logic        abort_pulse;

  // With both requesting, the one not served last wins; otherwise the lone one.
  assign grant_sel   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    fpu_op_d      = fpu_op_q;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    req_ack       = 2'b00;
    rsp_valid     = 2'b00;
    fpu_start     = 1'b0;
    abort_pulse   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (req_valid != 2'b00)) begin
          req_ack  = grant_sel ? 2'b10 : 2'b01;
          gnt_d    = grant_sel;
          last_d   = grant_sel;
          fpu_op_d = req_op[grant_sel];
          fpu_a_d  = grant_sel ? req_a[63:32] : req_a[31:0];
          fpu_b_d  = grant_sel ? req_b[63:32] : req_b[31:0];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        fpu_start = fpu_ready;
        if (fpu_ready) begin
          cnt_d   = 8'd0;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout_hit)     state_d = ABORT;
        else if (!fpu_ready) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_d = cnt_q + 8'd1;
        // Completion is checked first so a result arriving on the last allowed cycle is kept.
        if (fpu_ready) begin
          rsp_data_d    = fpu_c;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timeout_hit) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        abort_pulse   = 1'b1;
        rsp_data_d    = QNAN;
        rsp_timeout_d = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      gnt_q         <= 1'b0;
      cnt_q         <= 8'd0;
      rsp_data_q    <= 32'd0;
      rsp_timeout_q <= 1'b0;
      fpu_op_q      <= 1'b0;
      fpu_a_q       <= 32'd0;
      fpu_b_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      fpu_op_q      <= fpu_op_d;
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
    end
  end

  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign fpu_op      = fpu_op_q;
  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign busy        = (state_q != IDLE);
  assign fpu_rst     = rst | abort_pulse;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: FPU stub, transaction-level model checked every cycle,
// and directed scenarios with hand-computed results.
module tb_fpu_arbiter;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_op = 2'b00;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [1:0]  req_ack, rsp_valid;
  logic [31:0] rsp_data, fpu_a, fpu_b;
  logic        rsp_timeout, busy, fpu_start, fpu_op, fpu_rst;
  logic        fpu_ready;
  logic [31:0] fpu_c = '0;

  logic stub_busy = 1'b0;
  logic stub_hold = 1'b0;
  logic stub_hang = 1'b0;
  int   stub_lat  = 3;
  int   stub_cnt  = 0;

  always #5 clk = ~clk;

  fpu_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_ready(fpu_ready), .fpu_c(fpu_c), .fpu_rst(fpu_rst)
  );

  // Hand-computed IEEE-754 single results for the operand pairs used here.
  function automatic logic [31:0] fp_ref(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000; // 1+2
    if ( op && a == 32'h40000000 && b == 32'h3F800000) return 32'h3F800000; // 2-1
    if (!op && a == 32'h40400000 && b == 32'h3F800000) return 32'h40800000; // 3+1
    if ( op && a == 32'h40A00000 && b == 32'h40000000) return 32'h40400000; // 5-2
    if (!op && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000; // 2+2
    return 32'hDEADBEEF;
  endfunction

  // FPU stub: ready drops for stub_lat cycles after start, result sampled from held operands.
  assign fpu_ready = !stub_busy && !stub_hold;
  always @(posedge clk) begin
    if (fpu_rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (fpu_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= stub_lat;
    end else if (stub_busy && !stub_hang && stub_cnt <= 1) begin
      stub_busy <= 1'b0;
      fpu_c     <= fp_ref(fpu_op, fpu_a, fpu_b);
    end else if (stub_busy && !stub_hang) begin
      stub_cnt  <= stub_cnt - 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit in_txn, awaiting, waiting, seen_low, m_last, m_g, m_to_exp, m_to;
  logic [64:0] m_cap;
  logic [31:0] m_data;
  int start_cyc, exp_abort, exp_rsp;
  logic [1:0] acked;
  int starts = 0;
  int aborts = 0;
  int txns = 0;
  int rsp_cnt [2];
  int glog [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    in_txn = 0; awaiting = 0; waiting = 0; seen_low = 0;
    m_last = 1; m_g = 0; m_to_exp = 0; m_to = 0; m_data = '0; m_cap = '0;
    exp_rsp = -1; exp_abort = -1; acked = 2'b00;
  endtask

  task automatic compare();
    logic [1:0] exp_ack, exp_rv;
    logic g, exp_start;
    cyc++;
    if (rst) begin
      model_reset();
      chk("reset_outputs",
          {req_ack, rsp_valid, rsp_data, rsp_timeout, busy, fpu_start, fpu_op, fpu_a, fpu_b, fpu_rst},
          105'd1);
      return;
    end
    g = 1'b0;
    exp_ack = 2'b00;
    if (!in_txn && req_valid != 2'b00) begin
      g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      exp_ack = g ? 2'b10 : 2'b01;
    end
    chk("req_ack", req_ack, exp_ack);
    chk("busy", busy, in_txn);
    exp_start = awaiting && fpu_ready;
    chk("fpu_start", fpu_start, exp_start);
    if (in_txn) chk("fpu_operands", {fpu_op, fpu_a, fpu_b}, m_cap);
    chk("fpu_rst", fpu_rst, cyc == exp_abort);
    exp_rv = 2'b00;
    if (cyc == exp_rsp) begin
      exp_rv = m_g ? 2'b10 : 2'b01;
      m_data = m_to_exp ? 32'h7FC00000 : fp_ref(m_cap[64], m_cap[63:32], m_cap[31:0]);
      m_to   = m_to_exp;
    end
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_timeout", rsp_timeout, m_to);
    if (rsp_valid[0]) rsp_cnt[0]++;
    if (rsp_valid[1]) rsp_cnt[1]++;
    if (fpu_rst) aborts++;
    if (exp_start) begin
      starts++;
      awaiting = 0; waiting = 1; seen_low = 0; start_cyc = cyc;
      exp_abort = cyc + T + 1; exp_rsp = cyc + T + 2; m_to_exp = 1;
    end else if (waiting && cyc <= start_cyc + T) begin
      if (!fpu_ready) seen_low = 1;
      else if (seen_low) begin
        exp_rsp = cyc + 1; exp_abort = -1; m_to_exp = 0; waiting = 0;
      end
    end
    if (cyc == exp_rsp) begin
      txns++;
      $display("txn %0d: requester %0d data %08h timeout %0b cycle %0d", txns, m_g, rsp_data, rsp_timeout, cyc);
      in_txn = 0; waiting = 0; exp_rsp = -1; exp_abort = -1;
    end
    if (exp_ack != 2'b00) begin
      in_txn = 1; awaiting = 1; m_g = g; m_last = g;
      m_cap = {req_op[g], g ? req_a[63:32] : req_a[31:0], g ? req_b[63:32] : req_b[31:0]};
      glog.push_back(int'(g));
    end
    acked = req_ack;
  endtask

  // One clock: compare at the falling edge, then update requesters just after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acked;
    acked = 2'b00;
  endtask

  task automatic request(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    if (i == 0) begin req_a[31:0] = a; req_b[31:0] = b; end
    else        begin req_a[63:32] = a; req_b[63:32] = b; end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    tick();
    while ((req_valid != 2'b00 || busy || in_txn) && n < budget) begin
      tick();
      n++;
    end
    chk({"wait_", name}, n < budget, 1'b1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n0, s0, a0, r1, n;
    model_reset();
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_rsp_data", rsp_data, 32'h0);

    // Single add from requester 0
    stub_lat = 3;
    request(0, 1'b0, 32'h3F800000, 32'h40000000);
    wait_done("single", 40);
    chk("single_data", rsp_data, 32'h40400000);
    chk("single_timeout", rsp_timeout, 1'b0);
    chk("single_grant", glog[glog.size()-1], 0);
    chk("single_starts", starts, 1);

    // Round-robin from reset: 0,1 then 0,1 again
    reset_dut();
    n0 = glog.size();
    request(0, 1'b0, 32'h40400000, 32'h3F800000);
    request(1, 1'b1, 32'h40000000, 32'h3F800000);
    wait_done("rr1", 80);
    request(0, 1'b0, 32'h40400000, 32'h3F800000);
    request(1, 1'b1, 32'h40000000, 32'h3F800000);
    wait_done("rr2", 80);
    chk("rr_order", {glog[n0], glog[n0+1], glog[n0+2], glog[n0+3]}, {32'd0, 32'd1, 32'd0, 32'd1});
    chk("rr_last_data", rsp_data, 32'h3F800000);

    // Result arriving on the last allowed wait cycle completes normally
    stub_lat = T - 1;
    request(1, 1'b1, 32'h40A00000, 32'h40000000);
    wait_done("edge_ok", 60);
    chk("edge_ok_data", rsp_data, 32'h40400000);
    chk("edge_ok_timeout", rsp_timeout, 1'b0);

    // One cycle later is a timeout
    a0 = aborts;
    stub_lat = T;
    request(0, 1'b0, 32'h3F800000, 32'h40000000);
    wait_done("edge_to", 60);
    chk("edge_to_data", rsp_data, 32'h7FC00000);
    chk("edge_to_timeout", rsp_timeout, 1'b1);
    chk("edge_to_aborts", aborts, a0 + 1);

    // Non-terminating FPU operation
    a0 = aborts;
    stub_lat = 3;
    stub_hang = 1'b1;
    request(0, 1'b1, 32'h3F800000, 32'h3F800000);
    wait_done("hang", 80);
    stub_hang = 1'b0;
    chk("hang_data", rsp_data, 32'h7FC00000);
    chk("hang_timeout", rsp_timeout, 1'b1);
    chk("hang_aborts", aborts, a0 + 1);
    chk("hang_idle", busy, 1'b0);

    // FPU not ready for 5 cycles in ISSUE
    stub_hold = 1'b1;
    s0 = starts;
    n0 = glog.size();
    request(1, 1'b0, 32'h40000000, 32'h40000000);
    n = 0;
    while (glog.size() == n0 && n < 20) begin tick(); n++; end
    chk("hold_ack_seen", glog.size(), n0 + 1);
    repeat (5) tick();
    chk("hold_no_start", starts, s0);
    stub_hold = 1'b0;
    wait_done("hold", 40);
    chk("hold_one_start", starts, s0 + 1);
    chk("hold_data", rsp_data, 32'h40800000);

    // Requester 1 withdraws during RESP, requester 0 is served instead
    stub_lat = 4;
    n0 = glog.size();
    r1 = rsp_cnt[1];
    request(0, 1'b0, 32'h3F800000, 32'h40000000);
    n = 0;
    while (glog.size() == n0 && n < 20) begin tick(); n++; end
    request(0, 1'b0, 32'h40400000, 32'h3F800000);
    request(1, 1'b1, 32'h40000000, 32'h3F800000);
    n = 0;
    while (exp_rsp != cyc + 1 && n < 40) begin tick(); n++; end
    chk("withdraw_reached_resp", n < 40, 1'b1);
    req_valid[1] = 1'b0;
    wait_done("withdraw", 40);
    chk("withdraw_grants", {glog.size(), glog[glog.size()-1]}, {n0 + 2, 32'd0});
    chk("withdraw_no_rsp1", rsp_cnt[1], r1);
    chk("withdraw_data", rsp_data, 32'h40800000);

    // Reset during WAIT_HIGH, then a clean transaction
    stub_lat = 8;
    r1 = rsp_cnt[1];
    request(1, 1'b0, 32'h3F800000, 32'h40000000);
    n = 0;
    while (!(waiting && seen_low) && n < 20) begin tick(); n++; end
    tick();
    #1 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("midrst_no_rsp", rsp_cnt[1], r1);
    chk("midrst_data", rsp_data, 32'h0);
    stub_lat = 3;
    request(0, 1'b0, 32'h3F800000, 32'h40000000);
    wait_done("after_rst", 40);
    chk("after_rst_data", rsp_data, 32'h40400000);
    chk("after_rst_timeout", rsp_timeout, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
